// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer: 2-flop synchronizer, then one qualification FSM
// and counter per channel, producing a clean level plus press/release strobes.
module button_debounce #(
    parameter int unsigned NUM_BUTTONS     = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release
);

    localparam int unsigned CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 1 of the encoding is the debounced level.
    localparam logic [1:0] REL_STABLE = 2'b00;
    localparam logic [1:0] PRESS_WAIT = 2'b01;
    localparam logic [1:0] PRS_STABLE = 2'b10;
    localparam logic [1:0] REL_WAIT   = 2'b11;

    logic [NUM_BUTTONS-1:0] pressed_raw;
    logic [NUM_BUTTONS-1:0] sync1_q;
    logic [NUM_BUTTONS-1:0] sync2_q;

    assign pressed_raw = ACTIVE_LOW ? ~btn_raw : btn_raw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pressed_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        logic [1:0]       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             sample;

        assign sample = sync2_q[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                REL_STABLE: begin
                    if (sample) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sample) begin
                        state_d = REL_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = PRS_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PRS_STABLE: begin
                    if (!sample) begin
                        state_d = REL_WAIT;
                        cnt_d   = '0;
                    end
                end
                REL_WAIT: begin
                    if (sample) begin
                        state_d = PRS_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = REL_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = REL_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Strobes fire only on a completed qualification, never on a bounce abort.
        always_comb begin
            press_d   = (state_q == PRESS_WAIT) && (state_d == PRS_STABLE);
            release_d = (state_q == REL_WAIT) && (state_d == REL_STABLE);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q   <= REL_STABLE;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign btn_level[i]   = (state_q == PRS_STABLE) || (state_q == REL_WAIT);
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed vector table, corner-case sequences,
// and random bouncing stimulus against a sample-history reference model.
module tb_button_debounce;

    localparam int unsigned NB = 2;
    localparam int unsigned DC = 4;

    logic          clk;
    logic          reset_n;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    int total = 0;
    int bad   = 0;

    button_debounce #(
        .NUM_BUTTONS    (NB),
        .DEBOUNCE_CYCLES(DC),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level flips once the last DC+1 synchronized samples all disagree.
    logic [NB-1:0] m_s1, m_s2, m_level, m_press, m_rel;
    bit            hist [NB][$];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
        for (int c = 0; c < NB; c++) hist[c].delete();
    endtask

    task automatic model_edge();
        logic [NB-1:0] sample;
        bit            all_diff;
        sample  = m_s2;
        m_s2    = m_s1;
        m_s1    = ~btn_raw;
        m_press = '0;
        m_rel   = '0;
        for (int c = 0; c < NB; c++) begin
            hist[c].push_back(sample[c]);
            if (hist[c].size() > DC + 1) void'(hist[c].pop_front());
            all_diff = (hist[c].size() == DC + 1);
            foreach (hist[c][k]) if (hist[c][k] == m_level[c]) all_diff = 0;
            if (all_diff) begin
                m_level[c] = ~m_level[c];
                if (m_level[c]) m_press[c] = 1'b1;
                else            m_rel[c]   = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge; outputs compared 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        check("model_level", btn_level, m_level);
        check("model_press", btn_press, m_press);
        check("model_release", btn_release, m_rel);
    endtask

    typedef struct {
        logic [NB-1:0] raw;
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [NB-1:0] raw, input logic [NB-1:0] lvl,
                       input logic [NB-1:0] prs, input logic [NB-1:0] rel, input int n);
        vec_t v;
        v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel;
        repeat (n) vecs.push_back(v);
    endtask

    initial begin
        int rise, cnt0, cnt1, p0, p1;
        int hold [NB];
        bit pat [6];

        // Idle, 3-cycle glitch, clean press (edge 7), clean release (edge 7).
        add(2'b11, 2'b00, 2'b00, 2'b00, 5);
        add(2'b10, 2'b00, 2'b00, 2'b00, 3);
        add(2'b11, 2'b00, 2'b00, 2'b00, 8);
        add(2'b10, 2'b00, 2'b00, 2'b00, 6);
        add(2'b10, 2'b01, 2'b01, 2'b00, 1);
        add(2'b10, 2'b01, 2'b00, 2'b00, 5);
        add(2'b11, 2'b01, 2'b00, 2'b00, 6);
        add(2'b11, 2'b00, 2'b00, 2'b01, 1);
        add(2'b11, 2'b00, 2'b00, 2'b00, 3);

        reset_n = 1'b0;
        btn_raw = 2'b11;
        model_reset();
        #1;
        check("reset_level", btn_level, 2'b00);
        check("reset_press", btn_press, 2'b00);
        check("reset_release", btn_release, 2'b00);
        repeat (2) step();
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            btn_raw = vecs[i].raw;
            step();
            check($sformatf("vec%0d_level", i), btn_level, vecs[i].lvl);
            check($sformatf("vec%0d_press", i), btn_press, vecs[i].prs);
            check($sformatf("vec%0d_release", i), btn_release, vecs[i].rel);
        end

        // Bounce: low2/high1/low2/high1 then low held; final low is edge 7.
        pat = '{1, 1, 0, 1, 1, 0};
        rise = 0; cnt0 = 0;
        for (int e = 1; e <= 20; e++) begin
            btn_raw[0] = (e <= 6) ? ~pat[e-1] : 1'b0;
            step();
            if (btn_press[0]) cnt0++;
            if (btn_level[0] && rise == 0) rise = e;
        end
        check_int("bounce_rise_edge", rise, 13);
        check_int("bounce_press_count", cnt0, 1);
        btn_raw = 2'b11;
        repeat (12) step();

        // Independent channels, pressed two cycles apart.
        p0 = 0; p1 = 0; cnt0 = 0; cnt1 = 0;
        for (int e = 1; e <= 14; e++) begin
            btn_raw[0] = 1'b0;
            if (e >= 3) btn_raw[1] = 1'b0;
            step();
            if (btn_press[0]) begin cnt0++; if (p0 == 0) p0 = e; end
            if (btn_press[1]) begin cnt1++; if (p1 == 0) p1 = e; end
        end
        check_int("indep_press0_edge", p0, 7);
        check_int("indep_press1_edge", p1, 9);
        check_int("indep_press0_count", cnt0, 1);
        check_int("indep_press1_count", cnt1, 1);
        btn_raw[0] = 1'b1;
        repeat (12) step();
        check("pre_reset_level", btn_level, 2'b10);

        // Reset mid-WAIT on channel 0 while channel 1 is held pressed.
        btn_raw[0] = 1'b0;
        repeat (4) step();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midwait_reset_level", btn_level, 2'b00);
        check("midwait_reset_press", btn_press, 2'b00);
        check("midwait_reset_release", btn_release, 2'b00);
        repeat (2) step();
        reset_n = 1'b1;
        p0 = 0; p1 = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (btn_press[0] && p0 == 0) p0 = e;
            if (btn_press[1] && p1 == 0) p1 = e;
            if (e == 6) check("post_reset_level_e6", btn_level, 2'b00);
            if (e == 7) check("post_reset_level_e7", btn_level, 2'b11);
        end
        check_int("post_reset_press0_edge", p0, 7);
        check_int("post_reset_press1_edge", p1, 7);

        // Random bouncing with occasional resets, checked against the model every edge.
        for (int c = 0; c < NB; c++) hold[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NB; c++) begin
                if (hold[c] == 0) begin
                    btn_raw[c] = 1'($urandom_range(0, 1));
                    hold[c]    = int'($urandom_range(1, 9));
                end
                hold[c]--;
            end
            if ($urandom_range(0, 249) == 0) begin
                reset_n = 1'b0;
                model_reset();
                step();
                reset_n = 1'b1;
            end
            step();
            total++;
            if ((btn_press & btn_release) != '0) begin
                bad++;
                $display("FAIL press_release_overlap: got %b want 00", btn_press & btn_release);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
